result_dump_uart: RTL and testbench

Post-halt readout stage downstream of the processor control unit. When the core parks in its sink state (SK high), this block drives the control unit's `infer`/`infer_addr` port to read a window of data memory one word at a time. It waits out the memory read latency and captures `infer_data`. Each word is then serialized over a UART TX line (8N1, 4 bytes per word, most-significant byte first), so results can be read on a host terminal from the Basys3 USB-UART.

---
 rtl/result_dump_uart_pkg.sv | 21 ++
 rtl/result_dump_uart_tx_byte.sv | 72 +++++++
 rtl/result_dump_uart.sv | 167 ++++++++++++++++
 tb/tb_result_dump_uart.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/result_dump_uart_pkg.sv
// Shared definitions for the post-halt result dump: FSM state codes,
// UART frame constants and a byte-select helper.
package dump_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_LATCH = 3'd3;
    localparam state_t ST_SEND  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    localparam int UART_DATA_BITS = 8;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/result_dump_uart_tx_byte.sv
// 8N1 byte transmitter. The last cycle of the stop bit counts as idle so a
// new start can be accepted back-to-back without an inter-byte gap.
module uart_tx_byte
    import dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tx_busy,
    output logic       byte_done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DATA_LAST = 4'(UART_DATA_BITS);
    localparam logic [3:0]        STOP_IDX  = 4'(UART_DATA_BITS + 1);

    logic              active_r;
    logic [BAUD_W-1:0] baud_cnt_r;
    logic [3:0]        bit_idx_r;
    logic [7:0]        shift_r;
    logic              tx_r;
    logic              last_s;

    // Final cycle of the stop bit.
    always_comb begin
        last_s = active_r && (bit_idx_r == STOP_IDX) && (baud_cnt_r == BAUD_LAST);
    end

    assign byte_done = last_s;
    assign tx_busy   = active_r && !last_s;
    assign tx        = tx_r;

    // Baud and bit sequencing; bit index 0 is the start bit, 9 the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r   <= 1'b0;
            baud_cnt_r <= '0;
            bit_idx_r  <= 4'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
        end else if (start && !tx_busy) begin
            active_r   <= 1'b1;
            baud_cnt_r <= '0;
            bit_idx_r  <= 4'd0;
            shift_r    <= data;
            tx_r       <= 1'b0;
        end else if (active_r) begin
            if (baud_cnt_r == BAUD_LAST) begin
                baud_cnt_r <= '0;
                if (bit_idx_r == STOP_IDX) begin
                    active_r <= 1'b0;
                    tx_r     <= 1'b1;
                end else if (bit_idx_r == DATA_LAST) begin
                    bit_idx_r <= bit_idx_r + 4'd1;
                    tx_r      <= 1'b1;
                end else begin
                    bit_idx_r <= bit_idx_r + 4'd1;
                    tx_r      <= shift_r[0];
                    shift_r   <= {1'b0, shift_r[7:1]};
                end
            end else begin
                baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/result_dump_uart.sv
// Once the core halts, reads WORD_COUNT words through the control unit's
// infer port and streams each one MSB-byte first over the UART.
module result_dump_uart
    import dump_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 10416,
    parameter logic [15:0] START_ADDR   = 16'd0,
    parameter int          WORD_COUNT   = 16,
    parameter int          READ_LAT     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sk,
    output logic        infer,
    output logic [15:0] infer_addr,
    input  logic [31:0] infer_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] addr_r;
    logic [15:0] word_cnt_r;
    logic [15:0] lat_cnt_r;
    logic [31:0] word_r;
    logic [1:0]  idx_r;
    logic        infer_r;
    logic        busy_r;
    logic        done_r;
    logic        infer_nxt_s;
    logic        busy_nxt_s;
    logic        done_nxt_s;
    logic        start_s;
    logic [7:0]  tx_data_s;
    logic        tx_busy_s;
    logic        byte_done_s;
    logic        last_word_s;

    assign infer      = infer_r;
    assign infer_addr = addr_r;
    assign busy       = busy_r;
    assign done       = done_r;

    // Word counter reaches WORD_COUNT once the current word is sent.
    always_comb begin
        last_word_s = ((word_cnt_r + 16'd1) == 16'(WORD_COUNT));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; sk only matters in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sk) next_state_s = ST_REQ;
                else    next_state_s = ST_IDLE;
            end
            ST_REQ:  next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (lat_cnt_r <= 16'd1) next_state_s = ST_LATCH;
                else                    next_state_s = ST_WAIT;
            end
            ST_LATCH: next_state_s = ST_SEND;
            ST_SEND: begin
                if (byte_done_s && (idx_r == 2'd0)) begin
                    if (last_word_s) next_state_s = ST_DONE;
                    else             next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_DONE: next_state_s = ST_DONE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: the first byte starts straight from the read data in LATCH,
    // later bytes are chained on byte_done so no idle cycles appear between them.
    always_comb begin
        start_s     = 1'b0;
        tx_data_s   = 8'h00;
        infer_nxt_s = (next_state_s == ST_REQ) || (next_state_s == ST_WAIT);
        busy_nxt_s  = (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
        done_nxt_s  = (next_state_s == ST_DONE);
        case (state_r)
            ST_LATCH: begin
                start_s   = !tx_busy_s;
                tx_data_s = infer_data[31:24];
            end
            ST_SEND: begin
                if (byte_done_s && (idx_r != 2'd0)) begin
                    start_s   = 1'b1;
                    tx_data_s = word_byte(word_r, idx_r - 2'd1);
                end else begin
                    start_s   = 1'b0;
                    tx_data_s = 8'h00;
                end
            end
            default: begin
                start_s   = 1'b0;
                tx_data_s = 8'h00;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= START_ADDR;
            word_cnt_r <= 16'd0;
            lat_cnt_r  <= 16'd0;
            word_r     <= 32'h0000_0000;
            idx_r      <= 2'd0;
            infer_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            infer_r <= infer_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            case (state_r)
                ST_REQ: lat_cnt_r <= 16'(READ_LAT);
                ST_WAIT: begin
                    if (lat_cnt_r != 16'd0) lat_cnt_r <= lat_cnt_r - 16'd1;
                end
                ST_LATCH: begin
                    word_r <= infer_data;
                    idx_r  <= 2'(BYTES_PER_WORD - 1);
                end
                ST_SEND: begin
                    if (byte_done_s) begin
                        if (idx_r != 2'd0) begin
                            idx_r <= idx_r - 2'd1;
                        end else begin
                            addr_r     <= addr_r + 16'd1;
                            word_cnt_r <= word_cnt_r + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .data      (tx_data_s),
        .tx        (tx),
        .tx_busy   (tx_busy_s),
        .byte_done (byte_done_s)
    );

endmodule

// File: tb/tb_result_dump_uart.sv
// Scoreboard bench: three dump instances (single word, multi-word, address
// wrap) with per-instance memory models, UART decoders and read monitors.
module tb_result_dump_uart;

    localparam int CPB      = 4;
    localparam int RL       = 3;
    localparam int WORD_CYC = 40 * CPB + RL + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst = 3'b111;
    logic [2:0]  sk  = 3'b000;
    logic [2:0]  infer, tx, busy, done;
    logic [15:0] infer_addr [3];
    logic [31:0] infer_data [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int infer_rises [3] = '{0, 0, 0};

    logic [7:0]  exp_byte_q [3][$];
    logic [15:0] exp_addr_q [3][$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(int inst, logic [15:0] a);
        if (inst == 0 && a == 16'h0000) return 32'hDEADBEEF;
        if (inst == 1 && a == 16'h0000) return 32'h01020304;
        if (inst == 1 && a == 16'h0001) return 32'h00000000;
        if (inst == 1 && a == 16'h0002) return 32'hFFFFFFFF;
        if (inst == 2 && a == 16'hFFFF) return 32'hA55A3CC3;
        if (inst == 2 && a == 16'h0000) return 32'h12345678;
        return 32'h0BAD0BAD;
    endfunction

    function automatic logic [15:0] start_of(int inst);
        return (inst == 2) ? 16'hFFFF : 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input int inst, input logic [15:0] a);
        logic [31:0] w;
        w = mem_word(inst, a);
        exp_addr_q[inst].push_back(a);
        for (int b = 3; b >= 0; b--) exp_byte_q[inst].push_back(w[8*b +: 8]);
    endtask

    result_dump_uart #(.CLKS_PER_BIT(CPB), .START_ADDR(16'h0000), .WORD_COUNT(1), .READ_LAT(RL)) dut_a (
        .clk(clk), .rst(rst[0]), .sk(sk[0]), .infer(infer[0]), .infer_addr(infer_addr[0]),
        .infer_data(infer_data[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    result_dump_uart #(.CLKS_PER_BIT(CPB), .START_ADDR(16'h0000), .WORD_COUNT(3), .READ_LAT(RL)) dut_b (
        .clk(clk), .rst(rst[1]), .sk(sk[1]), .infer(infer[1]), .infer_addr(infer_addr[1]),
        .infer_data(infer_data[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    result_dump_uart #(.CLKS_PER_BIT(CPB), .START_ADDR(16'hFFFF), .WORD_COUNT(2), .READ_LAT(RL)) dut_c (
        .clk(clk), .rst(rst[2]), .sk(sk[2]), .infer(infer[2]), .infer_addr(infer_addr[2]),
        .infer_data(infer_data[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    for (genvar g = 0; g < 3; g++) begin : g_mon
        logic [31:0] pipe [RL];
        bit          factive = 1'b0;
        int          fcnt = 0;
        logic [7:0]  fsh = 8'h00;
        logic        prev_inf = 1'b0, prev_done = 1'b0, prev_busy = 1'b0;
        int          inf_len = 0, rise_cyc = 0;

        // Memory with READ_LAT cycles of latency.
        always @(posedge clk) begin
            pipe[0] <= mem_word(g, infer_addr[g]);
            for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
        end
        assign infer_data[g] = pipe[RL-1];

        // UART decoder, read monitor and done-timing monitor.
        always @(negedge clk) begin
            if (rst[g]) begin
                factive = 1'b0; prev_inf = 1'b0; prev_done = 1'b0; prev_busy = 1'b0;
            end else begin
                if (!factive) begin
                    if (tx[g] === 1'b0) begin factive = 1'b1; fcnt = 0; end
                end else begin
                    fcnt++;
                    if (fcnt == 2) check("start_bit", 32'(tx[g]), 32'd0);
                    if (fcnt >= 6 && fcnt <= 34 && ((fcnt - 2) % 4) == 0) fsh = {tx[g], fsh[7:1]};
                    if (fcnt == 38) begin
                        factive = 1'b0;
                        check("stop_bit", 32'(tx[g]), 32'd1);
                        if (exp_byte_q[g].size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_byte: inst %0d got %h expected none", g, fsh);
                        end else begin
                            check("uart_byte", 32'(fsh), 32'(exp_byte_q[g].pop_front()));
                        end
                    end
                end
                if (infer[g] && !prev_inf) begin
                    infer_rises[g]++;
                    rise_cyc = cyc;
                    inf_len  = 0;
                    if (exp_addr_q[g].size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_read: inst %0d got addr %h expected none", g, infer_addr[g]);
                    end else begin
                        check("read_addr", 32'(infer_addr[g]), 32'(exp_addr_q[g].pop_front()));
                    end
                end
                if (infer[g]) inf_len++;
                if (!infer[g] && prev_inf) check("infer_len", 32'(inf_len), 32'(RL + 1));
                if (done[g] && !prev_done) begin
                    check("done_latency", 32'(cyc - rise_cyc), 32'(WORD_CYC));
                    check("busy_fall", 32'({prev_busy, busy[g]}), 32'b10);
                end
                prev_inf  = infer[g];
                prev_done = done[g];
                prev_busy = busy[g];
            end
        end
    end

    initial begin
        int n;
        int idle_bad;
        int r0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_tx",    32'(tx[i]),    32'd1);
            check("rst_infer", 32'(infer[i]), 32'd0);
            check("rst_busy",  32'(busy[i]),  32'd0);
            check("rst_done",  32'(done[i]),  32'd0);
            check("rst_addr",  32'(infer_addr[i]), 32'(start_of(i)));
        end
        rst = 3'b000;

        idle_bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (tx !== 3'b111 || infer !== 3'b000) idle_bad++;
        end
        check("idle_line", 32'(idle_bad), 32'd0);

        push_word(0, 16'h0000);
        for (int w = 0; w < 3; w++) push_word(1, 16'(w));
        push_word(2, 16'hFFFF);
        push_word(2, 16'h0000);

        sk = 3'b111;
        @(posedge clk); #1;
        sk = 3'b000;

        n = 0;
        while (done !== 3'b111 && n < 3000) begin @(posedge clk); #1; n++; end
        check("dump_complete", 32'(done), 32'b111);
        check("busy_after_done", 32'(busy), 32'b000);
        for (int i = 0; i < 3; i++) begin
            check("bytes_left", 32'(exp_byte_q[i].size()), 32'd0);
            check("reads_left", 32'(exp_addr_q[i].size()), 32'd0);
        end

        r0 = infer_rises[0];
        sk[0] = 1'b1;
        @(posedge clk); #1;
        sk[0] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("no_restart", 32'(infer_rises[0]), 32'(r0));
        check("done_sticky", 32'(done[0]), 32'd1);
        check("done_tx_idle", 32'(tx[0]), 32'd1);

        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        push_word(0, 16'h0000);
        sk[0] = 1'b1;
        n = 0;
        while (infer[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("restart_infer", 32'(infer[0]), 32'd1);
        sk[0] = 1'b0;
        repeat (101) @(posedge clk);
        #1;
        check("mid_frame_busy", 32'(busy[0]), 32'd1);
        check("mid_frame_d3", 32'(tx[0]), 32'd1);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        check("mr_tx",    32'(tx[0]),    32'd1);
        check("mr_busy",  32'(busy[0]),  32'd0);
        check("mr_done",  32'(done[0]),  32'd0);
        check("mr_infer", 32'(infer[0]), 32'd0);
        check("mr_addr",  32'(infer_addr[0]), 32'h0000);
        check("mr_bytes_pending", 32'(exp_byte_q[0].size()), 32'd2);
        exp_byte_q[0].delete();
        exp_addr_q[0].delete();

        push_word(0, 16'h0000);
        sk[0] = 1'b1;
        @(posedge clk); #1;
        sk[0] = 1'b0;
        n = 0;
        while (done[0] !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        check("restart_done", 32'(done[0]), 32'd1);
        check("restart_bytes_left", 32'(exp_byte_q[0].size()), 32'd0);
        check("restart_reads_left", 32'(exp_addr_q[0].size()), 32'd0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
